// File: rtl/mult_pkg.sv
// Shared encodings and schedule constants for the sequential signed multiplier.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG_A  = 3'd1,
        NEG_B  = 3'd2,
        ITER   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5
    } state_t;

    localparam int ITER_COUNT   = 32;
    // Start-to-RDY distance in clock edges; the pipeline stall counter relies on it.
    localparam int MULT_LATENCY = 36;

endpackage

// File: rtl/add_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries, no carry input.
module add_32bit (
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        overflow
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [8:0]  w_gc;

    assign w_g = data_operandA & data_operandB;
    assign w_p = data_operandA ^ data_operandB;

    always_comb begin
        w_c  = '0;
        w_gc = '0;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | ((&w_p[4*k+1 -: 2]) & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | ((&w_p[4*k+2 -: 2]) & w_g[4*k])
                       | ((&w_p[4*k+2 -: 3]) & w_gc[k]);
            w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | ((&w_p[4*k+3 -: 2]) & w_g[4*k+1])
                       | ((&w_p[4*k+3 -: 3]) & w_g[4*k])
                       | ((&w_p[4*k+3 -: 4]) & w_gc[k]);
        end
    end

    assign data_result = w_p ^ w_c;
    assign overflow    = w_c[31] ^ w_gc[8];

endmodule

// File: rtl/mult_seq_32bit.sv
// Signed 32x32 shift-add multiplier on one shared adder; fixed 36-edge latency, low word + overflow flag.
// state | meaning: IDLE wait | NEG_A/NEG_B take |A|,|B| | ITER 32 shift-adds | FIX_LO/FIX_HI negate 64-bit product
module mult_seq_32bit
    import mult_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_neg_res;
    logic        r_lo_zero;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;
    logic        r_busy;

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_sum;
    logic        w_carry;
    logic        w_add_ovf_unused;

    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        case (r_state)
            NEG_A: begin
                w_add_a = r_mcand[31] ? ~r_mcand : r_mcand;
                w_add_b = {31'd0, r_mcand[31]};
            end
            NEG_B: begin
                w_add_a = r_lo[31] ? ~r_lo : r_lo;
                w_add_b = {31'd0, r_lo[31]};
            end
            ITER: begin
                w_add_a = r_hi;
                w_add_b = r_lo[0] ? r_mcand : '0;
            end
            FIX_LO: begin
                w_add_a = r_neg_res ? ~r_lo : r_lo;
                w_add_b = {31'd0, r_neg_res};
            end
            FIX_HI: begin
                w_add_a = r_neg_res ? ~r_hi : r_hi;
                w_add_b = {31'd0, r_neg_res & r_lo_zero};
            end
            default: ;
        endcase
    end

    add_32bit u_add (
        .data_operandA (w_add_a),
        .data_operandB (w_add_b),
        .data_result   (w_sum),
        .overflow      (w_add_ovf_unused)
    );

    // Unsigned carry-out recovered from the sum MSB, since the adder only exposes signed overflow.
    assign w_carry = (w_add_a[31] & w_add_b[31]) | ((w_add_a[31] | w_add_b[31]) & ~w_sum[31]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_lo_zero <= 1'b0;
            r_result  <= '0;
            r_exc     <= 1'b0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                NEG_A: begin
                    r_mcand <= w_sum;
                    r_state <= NEG_B;
                end
                NEG_B: begin
                    r_lo    <= w_sum;
                    r_state <= ITER;
                end
                ITER: begin
                    r_hi  <= {w_carry, w_sum[31:1]};
                    r_lo  <= {w_sum[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(ITER_COUNT - 1)) r_state <= FIX_LO;
                end
                FIX_LO: begin
                    r_lo_zero <= (r_lo == '0);
                    r_lo      <= w_sum;
                    r_state   <= FIX_HI;
                end
                FIX_HI: begin
                    r_hi     <= w_sum;
                    r_result <= r_lo;
                    r_exc    <= (w_sum != {32{r_lo[31]}});
                    r_rdy    <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: ;
            endcase
            // A start in any state wins over the schedule; FIX_HI above still delivers its result.
            if (ctrl_MULT) begin
                r_mcand   <= data_operandA;
                r_lo      <= data_operandB;
                r_hi      <= '0;
                r_cnt     <= '0;
                r_neg_res <= data_operandA[31] ^ data_operandB[31];
                r_busy    <= 1'b1;
                r_state   <= NEG_A;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Directed + random bench for mult_seq_32bit with an expected-result queue.
module tb_mult_seq_32bit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_seq_32bit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_const(input logic [31:0] res, input logic exc, input string tag);
        exp_t e;
        e.res = res;
        e.exc = exc;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_model(input logic [31:0] a, input logic [31:0] b, input string tag);
        longint p;
        logic [63:0] pv;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        push_const(pv[31:0], pv[63:32] != {32{pv[31]}}, tag);
    endtask

    task automatic pop_check;
        exp_t e;
        if (sb_q.size() == 0) begin
            check("unexpected_rdy", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_result"}, {32'd0, data_result}, {32'd0, e.res});
            check({e.tag, "_exc"}, {63'd0, data_exception}, {63'd0, e.exc});
        end
    endtask

    // Drives a start pulse; returns #1 after the sampling edge (edge 0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic watch(input int max_edges, output int rdy_edge, output int rdy_cnt,
                         output int busy_cnt);
        rdy_edge = -1;
        rdy_cnt  = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= max_edges; k++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (rdy_edge < 0) rdy_edge = k;
                pop_check();
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int re, rc, bc;
        start_op(a, b);
        watch(40, re, rc, bc);
        check({tag, "_rdy_edge"}, 64'(re), 64'd36);
        check({tag, "_rdy_count"}, 64'(rc), 64'd1);
    endtask

    initial begin
        int re, rc, bc;
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_result", {32'd0, data_result}, 64'd0);
        check("reset_exc", {63'd0, data_exception}, 64'd0);
        check("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        push_const(32'h0000000F, 1'b0, "3x5");
        start_op(32'd3, 32'd5);
        watch(40, re, rc, bc);
        check("3x5_rdy_edge", 64'(re), 64'd36);
        check("3x5_rdy_count", 64'(rc), 64'd1);
        check("3x5_busy_cycles", 64'(bc), 64'd36);

        push_const(32'hFFFFFFD6, 1'b0, "m7x6");
        run_op(-32'sd7, 32'd6, "m7x6");
        push_const(32'h00000000, 1'b0, "0xm5");
        run_op(32'd0, -32'sd5, "0xm5");
        push_const(32'h80000000, 1'b0, "min_x1");
        run_op(32'h80000000, 32'd1, "min_x1");
        push_const(32'h80000000, 1'b1, "min_xm1");
        run_op(32'h80000000, 32'hFFFFFFFF, "min_xm1");
        push_const(32'h00000000, 1'b1, "2p16sq");
        run_op(32'h00010000, 32'h00010000, "2p16sq");
        push_const(32'hFFFFFFFF, 1'b1, "ffff_x");
        run_op(32'h0000FFFF, 32'h00010001, "ffff_x");

        // Restart at edge 10: only the 2x2 result may appear, 36 edges after its own start.
        start_op(32'd100, 32'd100);
        for (int k = 1; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pop_check();
        end
        push_const(32'd4, 1'b0, "restart_2x2");
        start_op(32'd2, 32'd2);
        watch(40, re, rc, bc);
        check("restart_rdy_edge", 64'(re), 64'd36);
        check("restart_rdy_count", 64'(rc), 64'd1);

        // Start coinciding with FIX_HI: both results delivered.
        push_const(32'h0000000F, 1'b0, "coinc_first");
        start_op(32'd3, 32'd5);
        for (int k = 1; k < 36; k++) @(posedge clock);
        push_const(32'hFFFFFFF0, 1'b0, "coinc_second");
        start_op(32'd4, -32'sd4);
        check("coinc_first_rdy", {63'd0, data_resultRDY}, 64'd1);
        if (data_resultRDY) pop_check();
        check("coinc_busy_kept", {63'd0, busy}, 64'd1);
        watch(40, re, rc, bc);
        check("coinc_second_rdy_edge", 64'(re), 64'd36);

        // Reset at edge 20 of 9x9.
        start_op(32'd9, 32'd9);
        for (int k = 1; k <= 20; k++) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_result", {32'd0, data_result}, 64'd0);
        check("midrst_exc", {63'd0, data_exception}, 64'd0);
        check("midrst_rdy", {63'd0, data_resultRDY}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        watch(40, re, rc, bc);
        check("midrst_no_rdy", 64'(rc), 64'd0);
        push_const(32'd81, 1'b0, "after_rst_9x9");
        run_op(32'd9, 32'd9, "after_rst_9x9");

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : $urandom_range(0, 70000);
            push_model(a, b, $sformatf("rand%0d", i));
            run_op(a, b, $sformatf("rand%0d", i));
        end

        check("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
